// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan pattern engine.
package scan_pkg;

    typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, UNLOAD, DONE} state_t;

    // Width of a shift index that must hold 0..len-1.
    function automatic int idx_w(input int len);
        return (len < 2) ? 1 : $clog2(len);
    endfunction

endpackage

// File: rtl/scan_fail_log.sv
// Failure bookkeeping: saturating failing-slice counter, sticky chain mask
// and the location of the first failure since the last clear.
module scan_fail_log #(
    parameter int NUM_CHAINS = 50,
    parameter int PAT_W      = 16,
    parameter int BIT_W      = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [NUM_CHAINS-1:0] err,
    input  logic [PAT_W-1:0]      pat_idx,
    input  logic [BIT_W-1:0]      bit_idx,
    output logic [CNT_W-1:0]      fail_cnt,
    output logic [NUM_CHAINS-1:0] fail_chains,
    output logic [PAT_W-1:0]      first_fail_pat,
    output logic [BIT_W-1:0]      first_fail_bit
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt       <= '0;
            fail_chains    <= '0;
            first_fail_pat <= '0;
            first_fail_bit <= '0;
        end else if (clear) begin
            fail_cnt       <= '0;
            fail_chains    <= '0;
            first_fail_pat <= '0;
            first_fail_bit <= '0;
        end else if (|err) begin
            if (fail_cnt != '1)
                fail_cnt <= fail_cnt + CNT_W'(1);
            fail_chains <= fail_chains | err;
            // A zero count means nothing has failed yet in this run.
            if (fail_cnt == '0) begin
                first_fail_pat <= pat_idx;
                first_fail_bit <= bit_idx;
            end
        end
    end

endmodule

// File: rtl/scan_pattern_engine.sv
// Scan-test sequencer: streams pattern slices into parallel chains, runs the
// capture window between patterns and compares unloaded responses.
module scan_pattern_engine
    import scan_pkg::*;
#(
    parameter int NUM_CHAINS     = 50,
    parameter int CHAIN_LEN      = 16,
    parameter int CAPTURE_CYCLES = 1,
    parameter int PAT_W          = 16
) (
    input  logic                         sdram_clk,
    input  logic                         sdram_resetn,
    input  logic                         start,
    input  logic                         abort,
    input  logic [PAT_W-1:0]             num_patterns,
    output logic                         busy,
    output logic                         done,
    input  logic                         pat_valid,
    output logic                         pat_ready,
    input  logic [NUM_CHAINS-1:0]        pat_si,
    input  logic [NUM_CHAINS-1:0]        pat_exp,
    input  logic [NUM_CHAINS-1:0]        pat_mask,
    output logic                         test_se,
    output logic                         test_clk_en,
    output logic [NUM_CHAINS-1:0]        test_si,
    input  logic [NUM_CHAINS-1:0]        test_so,
    output logic [15:0]                  fail_cnt,
    output logic [NUM_CHAINS-1:0]        fail_chains,
    output logic [PAT_W-1:0]             first_fail_pat,
    output logic [$clog2(CHAIN_LEN)-1:0] first_fail_bit
);

    localparam int BIT_W = idx_w(CHAIN_LEN);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);
    localparam logic [1:0]       CAP_LAST = 2'(CAPTURE_CYCLES - 1);

    state_t                  state, next_state;
    logic [PAT_W-1:0]        pat_idx, num_lat, log_pat;
    logic [BIT_W-1:0]        bit_idx;
    logic [1:0]              cap_cnt;
    logic [NUM_CHAINS-1:0]   si_q, err;
    logic                    consume, compare, accept, clear, more;

    assign accept  = (state == IDLE) && start && !abort;
    assign clear   = accept && (num_patterns != '0);
    assign more    = ({1'b0, pat_idx} + (PAT_W+1)'(1)) < {1'b0, num_lat};
    assign busy    = (state == SHIFT) || (state == CAPTURE) || (state == UNLOAD);
    assign done    = (state == DONE);
    // Responses seen while shifting pattern N belong to pattern N-1.
    assign log_pat = pat_idx - PAT_W'(1);
    assign err     = compare ? ((test_so ^ pat_exp) & pat_mask) : '0;

    always_comb begin
        next_state  = state;
        test_se     = 1'b0;
        test_clk_en = 1'b0;
        pat_ready   = 1'b0;
        test_si     = si_q;
        case (state)
            IDLE: if (start) next_state = (num_patterns != '0) ? SHIFT : DONE;
            SHIFT: begin
                test_se     = 1'b1;
                pat_ready   = 1'b1;
                test_clk_en = pat_valid;
                if (pat_valid && bit_idx == LAST_BIT) next_state = CAPTURE;
            end
            CAPTURE: begin
                test_clk_en = 1'b1;
                if (cap_cnt == CAP_LAST) next_state = more ? SHIFT : UNLOAD;
            end
            UNLOAD: begin
                test_se     = 1'b1;
                pat_ready   = 1'b1;
                test_clk_en = pat_valid;
                test_si     = '0;
                if (pat_valid && bit_idx == LAST_BIT) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort) begin
            next_state  = IDLE;
            test_se     = 1'b0;
            test_clk_en = 1'b0;
            pat_ready   = 1'b0;
        end
        consume = pat_valid && pat_ready;
        compare = consume && ((state == UNLOAD) || (pat_idx != '0));
        if (state == SHIFT && consume) test_si = pat_si;
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state   <= IDLE;
            pat_idx <= '0;
            bit_idx <= '0;
            cap_cnt <= '0;
            num_lat <= '0;
            si_q    <= '0;
        end else begin
            state <= next_state;
            si_q  <= test_si;
            if (accept) begin
                pat_idx <= '0;
                bit_idx <= '0;
                cap_cnt <= '0;
                num_lat <= num_patterns;
            end
            if (consume)
                bit_idx <= (bit_idx == LAST_BIT) ? '0 : bit_idx + BIT_W'(1);
            if (state == CAPTURE && !abort) begin
                if (cap_cnt == CAP_LAST) begin
                    cap_cnt <= '0;
                    pat_idx <= pat_idx + PAT_W'(1);
                end else begin
                    cap_cnt <= cap_cnt + 2'd1;
                end
            end
        end
    end

    scan_fail_log #(
        .NUM_CHAINS (NUM_CHAINS),
        .PAT_W      (PAT_W),
        .BIT_W      (BIT_W),
        .CNT_W      (16)
    ) u_fail_log (
        .clk            (sdram_clk),
        .rst_n          (sdram_resetn),
        .clear          (clear),
        .err            (err),
        .pat_idx        (log_pat),
        .bit_idx        (bit_idx),
        .fail_cnt       (fail_cnt),
        .fail_chains    (fail_chains),
        .first_fail_pat (first_fail_pat),
        .first_fail_bit (first_fail_bit)
    );

endmodule
